// File: rtl/rtc_pkg.sv
// Shared types for the RTC read path.
//   rtc_addr_e  : field select encoding used by the host read port
//   rtc_time_t  : live/snapshot copy of every time counter field
//   rd_state_e  : read FSM states
//   HR_MODE_BIT / HR_PM_BIT : bit positions inside a 12h-mode hour byte
//   field_operand() : pick the binary operand for a given field select
package rtc_pkg;

    typedef enum logic [2:0] {
        ADDR_SEC     = 3'd0,
        ADDR_MIN     = 3'd1,
        ADDR_HOUR    = 3'd2,
        ADDR_DOW     = 3'd3,
        ADDR_DOM     = 3'd4,
        ADDR_MONTH   = 3'd5,
        ADDR_YEAR    = 3'd6,
        ADDR_CENTURY = 3'd7
    } rtc_addr_e;

    typedef struct packed {
        logic [5:0]  sec;
        logic [5:0]  min;
        logic [5:0]  hour;
        logic [1:0]  mode;          // bit0 = 12h mode, bit1 = PM
        logic [2:0]  day_of_week;
        logic [4:0]  day_of_month;
        logic [3:0]  month;
        logic [11:0] year;
    } rtc_time_t;

    localparam int unsigned HR_MODE_BIT = 6;
    localparam int unsigned HR_PM_BIT   = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StCompare,
        StConvert,
        StDone
    } rd_state_e;

    // Year and century both convert the full year; the byte select happens later.
    function automatic logic [11:0] field_operand(rtc_addr_e addr, rtc_time_t t);
        logic [11:0] op;
        unique case (addr)
            ADDR_SEC:     op = {6'd0, t.sec};
            ADDR_MIN:     op = {6'd0, t.min};
            ADDR_HOUR:    op = {6'd0, t.hour};
            ADDR_DOW:     op = {9'd0, t.day_of_week};
            ADDR_DOM:     op = {7'd0, t.day_of_month};
            ADDR_MONTH:   op = {8'd0, t.month};
            ADDR_YEAR:    op = t.year;
            ADDR_CENTURY: op = t.year;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/time_reader_if.sv
// Host-side read port of the RTC.
//   rd_req   : read request (master -> slave)
//   rd_addr  : field select (master -> slave)
//   rd_valid : one-cycle result strobe (slave -> master)
//   rd_data  : BCD result, held until the next strobe (slave -> master)
//   busy     : read in progress (slave -> master)
//   retry    : this read had to re-sample the live time (slave -> master)
interface time_reader_if;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       retry;

    modport master (
        output rd_req, rd_addr,
        input  rd_valid, rd_data, busy, retry
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_valid, rd_data, busy, retry
    );
endinterface

// File: rtl/time_reader_bin2bcd_seq.sv
// Iterative 12-bit double-dabble binary-to-BCD converter.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   start_i       : load bin_i and begin a conversion
//   bin_i         : 12-bit binary operand
//   done_o        : high for one cycle, BCD_ITER cycles after start_i
//   bcd_o         : four BCD digits {thousands, hundreds, tens, ones}
module bin2bcd_seq #(
    parameter int unsigned BCD_ITER = 12
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [11:0] bin_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    localparam int unsigned CntW = $clog2(BCD_ITER + 1);

    logic            run_q, run_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [11:0]     sr_q, sr_d;
    logic [15:0]     bcd_q, bcd_d;

    // One double-dabble step: correct every digit >= 5, then shift in the next bit.
    function automatic logic [15:0] dabble(logic [15:0] bcd, logic bit_in);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return {adj[14:0], bit_in};
    endfunction

    // The load edge already performs the first shift, so done_o lands exactly
    // BCD_ITER cycles after start_i with the final digits in bcd_q.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        sr_d  = sr_q;
        bcd_d = bcd_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = CntW'(BCD_ITER - 1);
            sr_d  = {bin_i[10:0], 1'b0};
            bcd_d = dabble(16'h0000, bin_i[11]);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
                sr_d  = {sr_q[10:0], 1'b0};
                bcd_d = dabble(bcd_q, sr_q[11]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            sr_q  <= '0;
            bcd_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            bcd_q <= bcd_d;
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/time_reader.sv
// Read-side port of the RTC: takes a coherent snapshot of the live time
// counter, converts the selected field to BCD and returns it as one byte.
//   clk_i, rstn_i   : system clock, asynchronous active-low reset
//   rd_if (slave)   : rd_req/rd_addr in; rd_valid/rd_data/busy/retry out
//   cur_*_i         : live fields from the time counter
module time_reader
    import rtc_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned BCD_ITER  = 12
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    time_reader_if.slave rd_if,
    input  logic [5:0]  cur_sec_i,
    input  logic [5:0]  cur_min_i,
    input  logic [5:0]  cur_hour_i,
    input  logic [1:0]  cur_mode_i,
    input  logic [2:0]  cur_day_of_week_i,
    input  logic [4:0]  cur_day_of_month_i,
    input  logic [3:0]  cur_month_i,
    input  logic [11:0] cur_year_i
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    rd_state_e   state_q, state_d;
    rtc_addr_e   addr_q;
    rtc_time_t   snap_q;
    rtc_time_t   live;
    logic [RetryW-1:0] retry_cnt_q;
    logic        retry_q;
    logic [7:0]  rd_data_q;

    logic        snap_ok;
    logic        accept, sample_en, retry_inc, bcd_start, load_data;
    logic        rd_valid, busy;
    logic        bcd_done;
    logic [15:0] bcd;
    logic [3:0]  d3, d2, d1, d0;
    logic [7:0]  fmt_data;

    assign live = '{sec:          cur_sec_i,
                    min:          cur_min_i,
                    hour:         cur_hour_i,
                    mode:         cur_mode_i,
                    day_of_week:  cur_day_of_week_i,
                    day_of_month: cur_day_of_month_i,
                    month:        cur_month_i,
                    year:         cur_year_i};

    // Once the retry budget is spent the latest snapshot is used even if stale.
    assign snap_ok = (snap_q == live) || (retry_cnt_q == RetryW'(MAX_RETRY));

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (rd_if.rd_req) state_d = StSample;
            StSample:  state_d = StCompare;
            StCompare: state_d = snap_ok ? StConvert : StSample;
            StConvert: if (bcd_done) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept    = 1'b0;
        sample_en = 1'b0;
        retry_inc = 1'b0;
        bcd_start = 1'b0;
        load_data = 1'b0;
        rd_valid  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            StIdle:    accept = rd_if.rd_req;
            StSample: begin
                busy      = 1'b1;
                sample_en = 1'b1;
            end
            StCompare: begin
                busy      = 1'b1;
                bcd_start = snap_ok;
                retry_inc = !snap_ok;
            end
            StConvert: begin
                busy      = 1'b1;
                load_data = bcd_done;
            end
            StDone:    rd_valid = 1'b1;
            default:   ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q      <= ADDR_SEC;
            snap_q      <= '0;
            retry_cnt_q <= '0;
            retry_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (accept) begin
                addr_q      <= rtc_addr_e'(rd_if.rd_addr);
                retry_cnt_q <= '0;
                retry_q     <= 1'b0;
            end
            if (sample_en) snap_q <= live;
            if (retry_inc) begin
                retry_cnt_q <= retry_cnt_q + 1'b1;
                retry_q     <= 1'b1;
            end
            if (load_data) rd_data_q <= fmt_data;
        end
    end

    bin2bcd_seq #(
        .BCD_ITER (BCD_ITER)
    ) u_bin2bcd (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (bcd_start),
        .bin_i   (field_operand(addr_q, snap_q)),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    assign {d3, d2, d1, d0} = bcd;

    // Byte formatting of the converted digits
    always_comb begin
        fmt_data = {d1, d0};
        case (addr_q)
            ADDR_CENTURY: fmt_data = {d3, d2};
            ADDR_HOUR: begin
                if (snap_q.mode[0]) begin
                    fmt_data              = {3'b000, d1[0], d0};
                    fmt_data[HR_MODE_BIT] = 1'b1;
                    fmt_data[HR_PM_BIT]   = snap_q.mode[1];
                end else begin
                    fmt_data[7:6] = 2'b00;
                end
            end
            default: ;
        endcase
    end

    assign rd_if.rd_valid = rd_valid;
    assign rd_if.rd_data  = rd_data_q;
    assign rd_if.busy     = busy;
    assign rd_if.retry    = retry_q;

endmodule

// File: tb/tb_time_reader.sv
// Self-checking bench for time_reader: expected bytes come from a decimal
// reference model and are queued on each accepted request; a monitor pops
// and compares on every rd_valid pulse.
module tb_time_reader;
    import rtc_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    time_reader_if rd_if ();
    rtc_time_t live;

    time_reader #(
        .MAX_RETRY (3),
        .BCD_ITER  (12)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .rd_if              (rd_if),
        .cur_sec_i          (live.sec),
        .cur_min_i          (live.min),
        .cur_hour_i         (live.hour),
        .cur_mode_i         (live.mode),
        .cur_day_of_week_i  (live.day_of_week),
        .cur_day_of_month_i (live.day_of_month),
        .cur_month_i        (live.month),
        .cur_year_i         (live.year)
    );

    typedef struct {
        logic [7:0] data;
        logic       retry;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digit extraction of the selected field.
    function automatic logic [7:0] ref_byte(input int addr, input rtc_time_t t);
        int v;
        int tens;
        int ones;
        case (addr)
            0:       v = int'(t.sec);
            1:       v = int'(t.min);
            2:       v = int'(t.hour);
            3:       v = int'(t.day_of_week);
            4:       v = int'(t.day_of_month);
            5:       v = int'(t.month);
            6:       v = int'(t.year) % 100;
            default: v = int'(t.year) / 100;
        endcase
        tens = (v / 10) % 10;
        ones = v % 10;
        if (addr == 2 && t.mode[0])
            return 8'(64 + (t.mode[1] ? 32 : 0) + (tens % 2) * 16 + ones);
        if (addr == 2)
            return 8'((tens * 16 + ones) % 64);
        return 8'(tens * 16 + ones);
    endfunction

    function automatic logic [5:0] sec_seq(input int k);
        return 6'((k * 7 + 3) % 60);
    endfunction

    always @(negedge clk) begin
        if (rstn && rd_if.rd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin : pop
                exp_t e;
                e = sb.pop_front();
                check("data", rd_if.rd_data, e.data);
                check("retry", rd_if.retry, e.retry);
                check("valid_cycle", cyc, e.cyc);
                check("busy_at_valid", rd_if.busy, 0);
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // kind 0: stable inputs (plus a request on the DONE cycle)
    // kind 1: live inputs switch to t_new one cycle after sampling
    // kind 2: sec changes every cycle, extra requests while busy
    task automatic do_read(input logic [2:0] addr, input int kind, input rtc_time_t t_new);
        int        c0;
        exp_t      e;
        rtc_time_t t7;
        @(negedge clk);
        c0 = cyc;
        rd_if.rd_req  = 1'b1;
        rd_if.rd_addr = addr;
        case (kind)
            0: begin
                e.data = ref_byte(int'(addr), live); e.retry = 1'b0; e.cyc = c0 + 15;
            end
            1: begin
                e.data = ref_byte(int'(addr), t_new); e.retry = 1'b1; e.cyc = c0 + 17;
            end
            default: begin
                // Samples land in cycles 1,3,5,7; the fourth is used as-is.
                t7 = live;
                t7.sec = sec_seq(7);
                e.data = ref_byte(int'(addr), t7); e.retry = 1'b1; e.cyc = c0 + 21;
            end
        endcase
        sb.push_back(e);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            rd_if.rd_req = 1'b0;
            if (k == 1) begin
                check("busy_after_accept", rd_if.busy, 1);
                check("retry_cleared", rd_if.retry, 0);
            end
            if (kind == 1 && k == 2) live = t_new;
            if (kind == 2) begin
                live.sec = sec_seq(k);
                if (k == 5 || k == 15) begin
                    rd_if.rd_req  = 1'b1;
                    rd_if.rd_addr = 3'd1;
                end
            end
            if (kind == 0 && k == 15) rd_if.rd_req = 1'b1;
        end
        wait_drain(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rtc_time_t tn;
        int        f;
        rstn          = 1'b0;
        rd_if.rd_req  = 1'b0;
        rd_if.rd_addr = 3'd0;
        live          = '0;
        #1;
        check("rst_valid", rd_if.rd_valid, 0);
        check("rst_data", rd_if.rd_data, 0);
        check("rst_busy", rd_if.busy, 0);
        check("rst_retry", rd_if.retry, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        live.sec = 6'd37;
        do_read(3'd0, 0, live);
        live.mode = 2'b11; live.hour = 6'd11;
        do_read(3'd2, 0, live);
        live.mode = 2'b00; live.hour = 6'd23;
        do_read(3'd2, 0, live);
        live.year = 12'd2024;
        do_read(3'd6, 0, live);
        do_read(3'd7, 0, live);
        live.year = 12'd2100;
        do_read(3'd6, 0, live);
        do_read(3'd7, 0, live);

        live.min = 6'd59;
        tn = live;
        tn.min = 6'd0;
        do_read(3'd1, 1, tn);

        do_read(3'd0, 2, live);

        // Abort a read in the middle of conversion.
        @(negedge clk);
        rd_if.rd_req  = 1'b1;
        rd_if.rd_addr = 3'd0;
        @(negedge clk);
        rd_if.rd_req = 1'b0;
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_valid", rd_if.rd_valid, 0);
        check("abort_data", rd_if.rd_data, 0);
        check("abort_busy", rd_if.busy, 0);
        check("abort_retry", rd_if.retry, 0);
        @(negedge clk);
        rstn = 1'b1;
        live.sec = 6'd42;
        do_read(3'd0, 0, live);

        for (int n = 0; n < 24; n++) begin
            live.sec          = 6'($urandom);
            live.min          = 6'($urandom);
            live.hour         = 6'($urandom);
            live.mode         = 2'($urandom);
            live.day_of_week  = 3'($urandom);
            live.day_of_month = 5'($urandom);
            live.month        = 4'($urandom);
            live.year         = 12'($urandom);
            tn = live;
            f  = int'($urandom_range(0, 3));
            case (f)
                0:       tn.sec  = tn.sec ^ 6'd1;
                1:       tn.min  = tn.min ^ 6'd1;
                2:       tn.hour = tn.hour ^ 6'd1;
                default: tn.year = tn.year ^ 12'd1;
            endcase
            do_read(3'($urandom_range(0, 7)), int'($urandom_range(0, 1)), tn);
        end

        wait_drain(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
